// File: rtl/core_mau_if.sv
// Data-bus interface between core_mau (master) and the memory system (slave).
// Handshake: the master raises bus_req with addr/we/wdata stable and holds them until
// the first cycle bus_ack=1 is sampled (or it aborts on timeout); bus_err and bus_rdata
// are only meaningful in that ack cycle, and bus_ack is ignored whenever bus_req=0.
interface core_mau_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/core_mau.sv
// Memory access unit for the i2d core: runs LD/ST from EX over a single-outstanding
// req/ack bus, stalls EX while busy, and reports misalign/bus-error/timeout faults.
package core_mau_pkg;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam logic [6:0] OPCODE_LD = 7'h03;
  localparam logic [6:0] OPCODE_ST = 7'h23;

  typedef struct packed {
    logic [24:0] fields;
    logic [6:0]  opcode;
  } instr_t;
endpackage

module core_mau
  import core_mau_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  instr_t      ex_instr,
  input  logic        ex_flush,
  input  data_t       mem_addr,
  input  data_t       st_data,
  output logic        mau_halt,
  output data_t       mau_data,
  output logic        mau_fault,
  output addr_t       fault_addr,
  core_mau_if.master  bus,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_BUSY   = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        req_q;
  logic        we_q;
  addr_t       addr_q;
  data_t       wdata_q;
  logic        killed;
  logic [15:0] cnt;

  logic mem_op;
  logic finish;
  logic kill_now;
  logic halt_raw;
  logic unused_instr;

  assign unused_instr = ^ex_instr.fields;

  assign mem_op   = ((ex_instr.opcode == OPCODE_LD) || (ex_instr.opcode == OPCODE_ST)) && !ex_flush;
  // An ack in the final counted cycle wins over the timeout.
  assign finish   = bus.bus_ack || (cnt == CNT_LAST);
  assign kill_now = killed || ex_flush;

  always_comb begin
    halt_raw = 1'b0;
    case (state)
      S_IDLE:  halt_raw = mem_op;
      S_BUSY:  halt_raw = 1'b1;
      default: halt_raw = 1'b0;
    endcase
  end

  assign mau_halt      = rst & halt_raw;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mau_data   <= '0;
      mau_fault  <= 1'b0;
      fault_addr <= '0;
      killed     <= 1'b0;
      cnt        <= '0;
    end else begin
      mau_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (mem_addr[1:0] != 2'b00) begin
              mau_fault  <= 1'b1;
              fault_addr <= mem_addr;
              state      <= S_DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= (ex_instr.opcode == OPCODE_ST);
              addr_q  <= {mem_addr[31:2], 2'b00};
              wdata_q <= st_data;
              cnt     <= '0;
              killed  <= 1'b0;
              state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt + 16'd1;
          if (ex_flush) killed <= 1'b1;
          if (finish) begin
            req_q  <= 1'b0;
            killed <= 1'b0;
            // A flushed access drains the bus but leaves no architectural trace.
            if (kill_now) begin
              state <= S_IDLE;
            end else begin
              state <= S_DONE;
              if (bus.bus_ack && !bus.bus_err) begin
                if (!we_q) mau_data <= bus.bus_rdata;
              end else begin
                mau_fault  <= 1'b1;
                fault_addr <= addr_q;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mau.sv
// Self-checking bench for core_mau: directed scenarios plus randomized accesses
// checked against a transaction-level model of the access rules.
module tb_core_mau;
  import core_mau_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  instr_t      ex_instr;
  logic        ex_flush;
  data_t       mem_addr;
  data_t       st_data;
  logic        mau_halt;
  data_t       mau_data;
  logic        mau_fault;
  addr_t       fault_addr;
  logic [1:0]  state_dbg;

  core_mau_if bus_if ();

  core_mau #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_instr   (ex_instr),
    .ex_flush   (ex_flush),
    .mem_addr   (mem_addr),
    .st_data    (st_data),
    .mau_halt   (mau_halt),
    .mau_data   (mau_data),
    .mau_fault  (mau_fault),
    .fault_addr (fault_addr),
    .bus        (bus_if),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Observations from the most recent access.
  int          halt_n, req_n, fault_n, first_req, last_req;
  bit          timed_out;
  logic [31:0] obs_addr, obs_wdata, done_data;
  logic        obs_we;

  // Reference model state and per-access predictions.
  logic [31:0] mdl_data, mdl_fa;
  int          exp_halt, exp_req, exp_fault;

  instr_t i_ld, i_st, i_nop;

  task automatic model_access(input logic is_ld, input logic [31:0] addr, input int ack_at,
                              input logic err, input logic [31:0] rdata, input int flush_at);
    int  c;
    bit  acked, killed;
    if (addr[1:0] != 2'b00) begin
      exp_halt = 1; exp_req = 0; exp_fault = 1; mdl_fa = addr;
    end else begin
      acked    = (ack_at >= 0) && (ack_at <= TO - 1);
      c        = acked ? ack_at : TO - 1;
      killed   = (flush_at >= 0) && (flush_at <= c);
      exp_req  = c + 1;
      exp_halt = c + 2;
      exp_fault = 0;
      if (!killed) begin
        if (acked && !err) begin
          if (is_ld) mdl_data = rdata;
        end else begin
          exp_fault = 1; mdl_fa = addr;
        end
      end
    end
  endtask

  // Drives one EX memory op from its IDLE cycle, acts as the bus slave, and returns
  // positioned one cycle past DONE (plus tail cycles) with observations filled in.
  task automatic do_access(input logic is_ld, input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic err, input logic [31:0] rdata,
                           input int flush_at, input int tail);
    int  since, tail_left;
    bit  started, done, ack;
    ex_instr = is_ld ? i_ld : i_st;
    mem_addr = addr; st_data = wd; ex_flush = 1'b0;
    halt_n = 0; req_n = 0; fault_n = 0; first_req = -1; last_req = -1;
    started = 0; done = 0; since = 0; tail_left = tail; timed_out = 0;
    for (int g = 0; g < 200; g++) begin
      if (bus_if.bus_req) begin
        if (!started) begin
          started = 1; since = 0; first_req = cycle;
          obs_addr = bus_if.bus_addr; obs_we = bus_if.bus_we; obs_wdata = bus_if.bus_wdata;
        end
        req_n++; last_req = cycle;
      end
      ack = started && (since == ack_at);
      bus_if.bus_ack   = ack;
      bus_if.bus_err   = ack ? err : 1'($urandom_range(0, 1));
      bus_if.bus_rdata = ack ? rdata : $urandom();
      if (started && since == flush_at) begin
        ex_flush = 1'b1; ex_instr = i_nop;
      end else begin
        ex_flush = 1'b0;
      end
      #1;
      if (mau_halt) halt_n++;
      else if (halt_n > 0 && !done) begin
        done = 1; done_data = mau_data; ex_instr = i_nop;
      end
      if (mau_fault) fault_n++;
      if (started) since++;
      @(posedge clk); #1; cycle++;
      if (done) begin
        if (tail_left == 0) break;
        tail_left--;
      end
    end
    if (!done) timed_out = 1;
    bus_if.bus_ack = 1'b0; ex_flush = 1'b0; ex_instr = i_nop;
  endtask

  task automatic test_reset();
    rst = 1'b0; ex_instr = i_ld; mem_addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (mau_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b exp 0", mau_halt); end
    n_tests++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", bus_if.bus_req); end
    n_tests++; if (mau_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", mau_data); end
    n_tests++; if (mau_fault !== 1'b0 || fault_addr !== 32'h0) begin n_fail++; $display("FAIL reset_fault: got %b/%h exp 0/0", mau_fault, fault_addr); end
    n_tests++; if (bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got we=%b addr=%h wdata=%h exp 0", bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata);
    end
    ex_instr = i_nop; mdl_data = '0; mdl_fa = '0;
    rst = 1'b1;
    @(posedge clk); #1; cycle++;
  endtask

  task automatic test_load();
    model_access(1'b1, 32'h100, 2, 1'b0, 32'hDEADBEEF, -1);
    do_access(1'b1, 32'h100, 32'h0, 2, 1'b0, 32'hDEADBEEF, -1, 1);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL load_done: access never completed"); end
    n_tests++; if (obs_addr !== 32'h100 || obs_we !== 1'b0) begin n_fail++; $display("FAIL load_bus: got addr=%h we=%b exp 100/0", obs_addr, obs_we); end
    n_tests++; if (halt_n != 4) begin n_fail++; $display("FAIL load_halt: got %0d exp 4", halt_n); end
    n_tests++; if (done_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data: got %h exp deadbeef", done_data); end
    n_tests++; if (fault_n != 0) begin n_fail++; $display("FAIL load_fault: got %0d pulses exp 0", fault_n); end
  endtask

  task automatic test_store();
    model_access(1'b0, 32'h204, 0, 1'b0, 32'hFFFF0000, -1);
    do_access(1'b0, 32'h204, 32'h12345678, 0, 1'b0, 32'hFFFF0000, -1, 1);
    n_tests++; if (obs_we !== 1'b1 || obs_wdata !== 32'h12345678 || obs_addr !== 32'h204) begin
      n_fail++; $display("FAIL store_bus: got we=%b wdata=%h addr=%h exp 1/12345678/204", obs_we, obs_wdata, obs_addr);
    end
    n_tests++; if (halt_n != 2) begin n_fail++; $display("FAIL store_halt: got %0d exp 2", halt_n); end
    n_tests++; if (mau_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_data: got %h exp deadbeef", mau_data); end
  endtask

  task automatic test_misaligned();
    model_access(1'b1, 32'h102, 0, 1'b0, 32'h0, -1);
    do_access(1'b1, 32'h102, 32'h0, 0, 1'b0, 32'h0, -1, 2);
    n_tests++; if (req_n != 0) begin n_fail++; $display("FAIL misalign_req: got %0d req cycles exp 0", req_n); end
    n_tests++; if (halt_n != 1) begin n_fail++; $display("FAIL misalign_halt: got %0d exp 1", halt_n); end
    n_tests++; if (fault_n != 1) begin n_fail++; $display("FAIL misalign_fault: got %0d pulses exp 1", fault_n); end
    n_tests++; if (fault_addr !== 32'h102) begin n_fail++; $display("FAIL misalign_addr: got %h exp 102", fault_addr); end
  endtask

  task automatic test_timeout();
    model_access(1'b1, 32'h300, TO + 1, 1'b0, 32'h55555555, -1);
    do_access(1'b1, 32'h300, 32'h0, TO + 1, 1'b0, 32'h55555555, -1, 4);
    n_tests++; if (req_n != TO) begin n_fail++; $display("FAIL timeout_req: got %0d cycles exp %0d", req_n, TO); end
    n_tests++; if (fault_n != 1 || fault_addr !== 32'h300) begin n_fail++; $display("FAIL timeout_fault: got %0d/%h exp 1/300", fault_n, fault_addr); end
    n_tests++; if (mau_data !== mdl_data) begin n_fail++; $display("FAIL timeout_late_ack: got %h exp %h", mau_data, mdl_data); end
  endtask

  task automatic test_flush();
    logic [31:0] old;
    old = mdl_data;
    model_access(1'b1, 32'h400, 3, 1'b0, 32'hAAAA5555, 0);
    do_access(1'b1, 32'h400, 32'h0, 3, 1'b0, 32'hAAAA5555, 0, 3);
    n_tests++; if (mau_data !== old) begin n_fail++; $display("FAIL flush_data: got %h exp %h", mau_data, old); end
    n_tests++; if (fault_n != 0) begin n_fail++; $display("FAIL flush_fault: got %0d pulses exp 0", fault_n); end
    n_tests++; if (halt_n != exp_halt || req_n != exp_req) begin
      n_fail++; $display("FAIL flush_idle: got halt=%0d req=%0d exp %0d/%0d", halt_n, req_n, exp_halt, exp_req);
    end
  endtask

  task automatic test_back_to_back();
    int prev_last;
    model_access(1'b1, 32'h600, 1, 1'b0, 32'h0BADF00D, -1);
    do_access(1'b1, 32'h600, 32'h0, 1, 1'b0, 32'h0BADF00D, -1, 0);
    prev_last = last_req;
    n_tests++; if (done_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_data1: got %h exp 0badf00d", done_data); end
    model_access(1'b1, 32'h604, 0, 1'b0, 32'hCAFEF00D, -1);
    do_access(1'b1, 32'h604, 32'h0, 0, 1'b0, 32'hCAFEF00D, -1, 1);
    n_tests++; if (first_req - prev_last != 3) begin n_fail++; $display("FAIL b2b_gap: got %0d exp 3", first_req - prev_last); end
    n_tests++; if (done_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data2: got %h exp cafef00d", done_data); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic        ld, er;
    int          ack_at, fl, tl;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1));
      a  = $urandom();
      a  = (a & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      wd = $urandom(); rd = $urandom();
      ack_at = $urandom_range(0, TO);
      er = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO - 1) : -1;
      tl = $urandom_range(0, 2);
      model_access(ld, a, ack_at, er, rd, fl);
      do_access(ld, a, wd, ack_at, er, rd, fl, tl);
      n_tests++;
      if (timed_out || halt_n != exp_halt || req_n != exp_req || fault_n != exp_fault) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got halt=%0d req=%0d fault=%0d exp %0d/%0d/%0d", i, halt_n, req_n, fault_n, exp_halt, exp_req, exp_fault);
      end
      n_tests++; if (mau_data !== mdl_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h exp %h", i, mau_data, mdl_data); end
      n_tests++; if (fault_addr !== mdl_fa) begin n_fail++; $display("FAIL rand_faddr[%0d]: got %h exp %h", i, fault_addr, mdl_fa); end
      if (exp_req > 0) begin
        n_tests++;
        if (obs_addr !== a || obs_we !== !ld || (!ld && obs_wdata !== wd)) begin
          n_fail++; $display("FAIL rand_bus[%0d]: got addr=%h we=%b wdata=%h exp %h/%b/%h", i, obs_addr, obs_we, obs_wdata, a, !ld, wd);
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    int g;
    ex_instr = i_ld; mem_addr = 32'h500; st_data = '0;
    g = 0;
    while (!bus_if.bus_req && g < 10) begin
      @(posedge clk); #1; cycle++; g++;
    end
    n_tests++; if (!bus_if.bus_req) begin n_fail++; $display("FAIL rstbusy_start: got req=0 exp 1"); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (bus_if.bus_req !== 1'b0 || mau_halt !== 1'b0 || mau_data !== 32'h0) begin
      n_fail++; $display("FAIL rstbusy_async: got req=%b halt=%b data=%h exp 0/0/0", bus_if.bus_req, mau_halt, mau_data);
    end
    mdl_data = '0; mdl_fa = '0; ex_instr = i_nop;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1; cycle++;
    model_access(1'b1, 32'h504, 1, 1'b0, 32'h600DCAFE, -1);
    do_access(1'b1, 32'h504, 32'h0, 1, 1'b0, 32'h600DCAFE, -1, 1);
    n_tests++; if (done_data !== 32'h600DCAFE || halt_n != 3) begin
      n_fail++; $display("FAIL rstbusy_fresh: got data=%h halt=%0d exp 600dcafe/3", done_data, halt_n);
    end
  endtask

  initial begin
    i_ld  = '0; i_ld.opcode  = OPCODE_LD;
    i_st  = '0; i_st.opcode  = OPCODE_ST;
    i_nop = '0; i_nop.opcode = 7'h13;
    ex_instr = i_nop; ex_flush = 1'b0; mem_addr = '0; st_data = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;
    rst = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mau.md
# core_mau

Memory access unit for the i2d core. Executes OPCODE_LD and OPCODE_ST for the instruction currently in the EX stage over a single-outstanding req/ack data bus. Stalls the pipeline through `mau_halt` until the access completes, then presents registered load data on `mau_data` for EX writeback. Reports misaligned accesses, bus errors and bus timeouts as a one-cycle fault with a captured address.

## Interface
- `TIMEOUT`, default 256: maximum cycles `bus_req` stays high without `bus_ack` before the access is aborted as a fault. Legal range 2..65535.
- `clk` input 1: core clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `ex_instr` input instr_t: instruction in EX. Only `opcode` is used (OPCODE_LD, OPCODE_ST).
- `ex_flush` input 1: EX flush. Same pulse that turns EX into a flush NOP.
- `mem_addr` input data_t: effective address, which is the ALU result for `ex_instr`.
- `st_data` input data_t: store data for OPCODE_ST.
- `mau_halt` output 1: stall request, ORed into `ex_halt` upstream.
- `mau_data` output data_t: last completed load word, registered.
- `mau_fault` output 1: one-cycle fault pulse.
- `fault_addr` output addr_t: address of the faulting access, held until the next fault.
- `bus_req` output 1: bus request, registered.
- `bus_we` output 1: 1 for store, 0 for load.
- `bus_addr` output addr_t: word address. Bits [1:0] are always 0.
- `bus_wdata` output data_t: store data.
- `bus_ack` input 1: transfer complete, sampled only while `bus_req`=1.
- `bus_err` input 1: error qualifier, valid only with `bus_ack`.
- `bus_rdata` input data_t: load data, valid with `bus_ack`.

## Operation
- Memory op: `ex_instr.opcode` is LD or ST, and `ex_flush`=0.
- FSM states:
  - **IDLE**: on a memory op, `mau_halt`=1 combinationally.
    - If `mem_addr[1:0]`≠0: go to DONE with fault set; no bus access.
    - Otherwise: latch `bus_addr`, `bus_we`, `bus_wdata`, set `bus_req`=1, clear the timeout counter, and go to BUSY.
  - **BUSY**: `mau_halt`=1, `bus_req`=1, outputs stable. The counter increments each cycle.
    - `bus_ack`=1 and `bus_err`=0: a load captures `bus_rdata` into `mau_data`. Drop `bus_req` and go to DONE.
    - `bus_ack`=1 and `bus_err`=1: drop `bus_req`, set fault, and go to DONE. `mau_data` is unchanged.
    - Counter reaches TIMEOUT-1 without ack: drop `bus_req`, set fault, and go to DONE.
  - **DONE**: `mau_halt`=0, so EX consumes `mau_data` and the pipeline advances on this edge. `mau_fault`=1 for this cycle only if fault is set. Always go to IDLE next cycle. This prevents re-issuing the same instruction.
- Flush:
  - `ex_flush` in IDLE: no access starts.
  - `ex_flush` during BUSY: the bus transfer runs to ack or timeout and `mau_halt` stays 1. The FSM sets a `killed` flag. When `killed` is set, completion does not update `mau_data`, `mau_fault` or `fault_addr`, and the FSM goes straight to IDLE.
- Stores never modify `mau_data`.
- Fault: `fault_addr` ← the access address (unaligned `mem_addr` for alignment faults).

## Timing
- Reset values: FSM=IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `mau_data`=0, `mau_fault`=0, `fault_addr`=0, `killed`=0, counter=0. `mau_halt`=0 while `rst`=0.
- Aligned access, ack N cycles after `bus_req` rises (N≥0, ack in first BUSY cycle is N=0): `mau_halt` is high for N+2 cycles, and `mau_data` is valid in the DONE cycle. The minimum access occupies 3 cycles in EX (IDLE, BUSY, DONE).
- Misaligned access: `mau_halt` is high for 1 cycle, then DONE with `mau_fault`=1.
- `bus_req` deasserts on the edge after the ack sample. A back-to-back memory op re-raises it no earlier than 2 cycles later.
- Timeout: `bus_req` is high exactly TIMEOUT cycles. A late `bus_ack` while `bus_req`=0 is ignored.
- Reset asserted mid-BUSY: `bus_req` drops immediately (asynchronously) and the transaction is abandoned.
- `ex_flush` and `bus_ack` in the same BUSY cycle: treated as killed, so no data or fault update.

## Test plan
- LD, `mem_addr`=0x100, ack with `bus_rdata`=0xDEADBEEF 2 cycles after `bus_req`: `bus_addr`=0x100, `bus_we`=0, `mau_halt` high 4 cycles, `mau_data`=0xDEADBEEF in DONE, `mau_fault`=0.
- ST, `mem_addr`=0x204, `st_data`=0x12345678, ack 0 cycles after `bus_req`: `bus_we`=1, `bus_wdata`=0x12345678, `mau_halt` high 2 cycles, `mau_data` unchanged.
- LD, `mem_addr`=0x102: no `bus_req`, `mau_fault` pulses 1 cycle, `fault_addr`=0x102.
- TIMEOUT=4, LD to 0x300, never ack: `bus_req` high exactly 4 cycles, then `mau_fault`=1 with `fault_addr`=0x300. Ack 2 cycles later is ignored.
- LD in BUSY, `ex_flush` pulse, ack 3 cycles later with `bus_rdata`=0xAAAA5555: `mau_data` keeps its old value, no fault, FSM returns to IDLE.
- `rst` low during BUSY: `bus_req`, `mau_halt` and `mau_data` are 0 in the same cycle. After release, a fresh LD completes normally.
